// File: rtl/bram_read_arbiter.sv
// Round-robin, burst-granular arbiter for the single read port of the coefficient/data BRAM.
// Issues one address per cycle and delays valid/id/last to line up with bram_dout.
module bram_read_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_base,
  input  logic [ADDR_W-1:0] req0_len,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_base,
  input  logic [ADDR_W-1:0] req1_len,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              out_last,
  output logic              busy
);

  // Handshake: a request transfers in the cycle where reqN_valid & reqN_ready;
  // requesters keep valid/base/len stable until then, and ready is only ever
  // raised in IDLE, so at most one request is accepted per burst slot.
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_last;
  logic              r_en;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_cnt;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pid;
  logic [RD_LAT-1:0] r_plast;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_issue_last;

  assign w_issue_last = (r_cnt == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie, the requester that was not served last wins.
        if (req0_valid && (!req1_valid || r_rr_last)) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_issue_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_en      <= 1'b0;
      r_id      <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant0 || w_grant1) begin
        r_addr    <= w_grant1 ? req1_base : req0_base;
        r_len     <= w_grant1 ? req1_len : req0_len;
        r_id      <= w_grant1;
        r_rr_last <= w_grant1;
        r_cnt     <= '0;
        r_en      <= 1'b1;
      end else if (r_state == S_BURST) begin
        if (w_issue_last) begin
          r_en <= 1'b0;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Tag pipeline: stage 0 captures the word issued this cycle, the last stage
  // lines up with bram_dout. Reset flushes words already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv    <= '0;
      r_pid   <= '0;
      r_plast <= '0;
    end else begin
      r_pv[0]    <= r_en;
      r_pid[0]   <= r_en & r_id;
      r_plast[0] <= r_en & w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pid[i]   <= r_pid[i-1];
        r_plast[i] <= r_plast[i-1];
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign bram_en    = r_en;
  assign bram_addr  = r_addr;
  assign out_valid  = r_pv[RD_LAT-1];
  assign out_id     = r_pid[RD_LAT-1];
  assign out_last   = r_plast[RD_LAT-1];
  assign out_data   = bram_dout;
  assign busy       = (r_state == S_BURST) | (|r_pv);

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: a per-cycle vector table on an RD_LAT=1 instance,
// plus hand sequences for round-robin alternation, mid-burst reset and an RD_LAT=3 instance.
module tb_bram_read_arbiter;

  localparam int AW = 4;
  localparam int DW = 1024;

  logic clk;
  logic rst;

  // RD_LAT=1 instance
  logic          v0, v1, r0, r1;
  logic [AW-1:0] b0, l0, b1, l1;
  logic          en1, ov1, oid1, olast1, busy1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1, od1;

  // RD_LAT=3 instance
  logic          q0v, q1v, q0r, q1r;
  logic [AW-1:0] q0b, q0l, q1b, q1l;
  logic          en3, ov3, oid3, olast3, busy3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] d3_a, d3_b, dout3, od3;

  int n_vec;
  int n_mis;

  bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_base(b0), .req0_len(l0),
    .req1_valid(v1), .req1_ready(r1), .req1_base(b1), .req1_len(l1),
    .bram_en(en1), .bram_addr(addr1), .bram_dout(dout1),
    .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_last(olast1), .busy(busy1)
  );

  bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(q0v), .req0_ready(q0r), .req0_base(q0b), .req0_len(q0l),
    .req1_valid(q1v), .req1_ready(q1r), .req1_base(q1b), .req1_len(q1l),
    .bram_en(en3), .bram_addr(addr3), .bram_dout(dout3),
    .out_valid(ov3), .out_data(od3), .out_id(oid3), .out_last(olast3), .busy(busy3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // BRAM contents: each word is a recognisable pattern of its address.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {32{{28'hC0FFEE0, a}}};
  endfunction

  always @(posedge clk) dout1 <= data_of(addr1);
  always @(posedge clk) begin
    d3_a  <= data_of(addr3);
    d3_b  <= d3_a;
    dout3 <= d3_b;
  end

  // Scoreboard helpers
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got word %0h expected word %0h", nm, act[31:0], exp[31:0]);
    end
  endtask

  task automatic wait_idle1(input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      #2;
      if (!busy1) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_mis++;
      $display("FAIL %s: busy still 1 after 50 cycles, expected 0", nm);
    end
  endtask

  typedef struct {
    logic rst, v0;
    logic [AW-1:0] b0, l0;
    logic v1;
    logic [AW-1:0] b1, l1;
    logic r0, r1, en;
    logic [AW-1:0] addr;
    logic ov, id, last, busy;
    logic [AW-1:0] word;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic a0v, input logic [AW-1:0] a0b, input logic [AW-1:0] a0l,
                              input logic a1v, input logic [AW-1:0] a1b, input logic [AW-1:0] a1l,
                              input logic er0, input logic er1, input logic een, input logic [AW-1:0] eaddr,
                              input logic eov, input logic eid, input logic elast, input logic ebusy,
                              input logic [AW-1:0] eword);
    vec_t v;
    v.rst = rs; v.v0 = a0v; v.b0 = a0b; v.l0 = a0l; v.v1 = a1v; v.b1 = a1b; v.l1 = a1l;
    v.r0 = er0; v.r1 = er1; v.en = een; v.addr = eaddr;
    v.ov = eov; v.id = eid; v.last = elast; v.busy = ebusy; v.word = eword;
    return v;
  endfunction

  vec_t tbl[21];
  logic exp_q[$];

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    v0 = 0; b0 = 0; l0 = 0; v1 = 0; b1 = 0; l1 = 0;
    q0v = 0; q0b = 0; q0l = 0; q1v = 0; q1b = 0; q1l = 0;

    //              rst v0 b0 l0 v1 b1  l1   r0 r1 en addr ov id la bu word
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0, 0, 0, 0, 0);
    // single burst req0 base=3 len=2
    tbl[1]  = mk(0, 1, 3, 2, 0, 0,  0,   1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 3,  0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 4,  1, 0, 0, 1, 3);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 5,  1, 0, 0, 1, 4);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 5,  1, 0, 1, 1, 5);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 5,  0, 0, 0, 0, 0);
    // reset, then tie with len=0 each: req0 first, req1 two cycles later
    tbl[7]  = mk(1, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 7, 0, 1, 9,  0,   1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 9,  0,   0, 0, 1, 7,  0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 9,  0,   0, 1, 0, 7,  1, 0, 1, 1, 7);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 9,  0, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 9,  1, 1, 1, 1, 9);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 9,  0, 0, 0, 0, 0);
    // req1 base=14 len=3: address wraps 15 -> 0
    tbl[14] = mk(0, 0, 0, 0, 1, 14, 3,   0, 1, 0, 9,  0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 14, 0, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 15, 1, 1, 0, 1, 14);
    tbl[17] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 0,  1, 1, 0, 1, 15);
    tbl[18] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 1,  1, 1, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 1,  1, 1, 1, 1, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 1,  0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      v0 = tbl[i].v0; b0 = tbl[i].b0; l0 = tbl[i].l0;
      v1 = tbl[i].v1; b1 = tbl[i].b1; l1 = tbl[i].l1;
      #2;
      chk1($sformatf("row%0d_req0_ready", i), r0, tbl[i].r0);
      chk1($sformatf("row%0d_req1_ready", i), r1, tbl[i].r1);
      chk1($sformatf("row%0d_bram_en", i), en1, tbl[i].en);
      chk4($sformatf("row%0d_bram_addr", i), addr1, tbl[i].addr);
      chk1($sformatf("row%0d_out_valid", i), ov1, tbl[i].ov);
      chk1($sformatf("row%0d_out_last", i), olast1, tbl[i].last);
      chk1($sformatf("row%0d_busy", i), busy1, tbl[i].busy);
      if (tbl[i].ov || tbl[i].rst) begin
        chk1($sformatf("row%0d_out_id", i), oid1, tbl[i].id);
      end
      if (tbl[i].ov) begin
        chkd($sformatf("row%0d_out_data", i), od1, data_of(tbl[i].word));
      end
    end

    // Round-robin: req0 held continuously, req1 joins during req0's first burst.
    begin
      int  n_g;
      bit  raise1;
      bit  drop;
      n_g = 0; raise1 = 0; drop = 0;
      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      @(negedge clk);
      v0 = 1; b0 = 2; l0 = 1;
      for (int c = 0; c < 40 && n_g < 4; c++) begin
        if (c != 0) @(negedge clk);
        if (raise1) begin v1 = 1; b1 = 10; l1 = 1; raise1 = 0; end
        #2;
        if (r0 && r1) begin
          n_vec++; n_mis++;
          $display("FAIL rr_both_ready: got both ready=1 expected one");
        end else if (r0 || r1) begin
          chk1($sformatf("rr_grant%0d", n_g), r1, exp_q.pop_front());
          if (n_g == 0) raise1 = 1;
          n_g++;
        end
      end
      n_vec++;
      if (n_g != 4) begin
        n_mis++;
        $display("FAIL rr_grant_count: got %0d grants expected 4", n_g);
      end
      @(negedge clk);
      v0 = 0; v1 = 0;
      wait_idle1("rr_drain");
    end

    // Mid-burst reset: req0 len=7 burst sets the RR pointer to 0 before reset.
    @(negedge clk);
    v0 = 1; b0 = 0; l0 = 7;
    #2;
    chk1("mrst_grant", r0, 1'b1);
    @(negedge clk);
    v0 = 0;
    #2;
    chk4("mrst_word0_addr", addr1, 4'd0);
    @(negedge clk);
    #2;
    chk4("mrst_word1_addr", addr1, 4'd1);
    chk1("mrst_word0_valid", ov1, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("mrst_en", en1, 1'b0);
    chk4("mrst_addr", addr1, 4'd0);
    chk1("mrst_valid", ov1, 1'b0);
    chk1("mrst_id", oid1, 1'b0);
    chk1("mrst_last", olast1, 1'b0);
    chk1("mrst_busy", busy1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk1($sformatf("mrst_quiet_valid%0d", c), ov1, 1'b0);
      chk1($sformatf("mrst_quiet_en%0d", c), en1, 1'b0);
      @(negedge clk);
    end
    v0 = 1; b0 = 5; l0 = 0; v1 = 1; b1 = 6; l1 = 0;
    #2;
    chk1("mrst_tie_r0", r0, 1'b1);
    chk1("mrst_tie_r1", r1, 1'b0);
    @(negedge clk);
    v0 = 0;
    @(negedge clk);
    #2;
    chk1("mrst_second_r1", r1, 1'b1);
    chk1("mrst_first_word_id", oid1, 1'b0);
    @(negedge clk);
    v1 = 0;
    wait_idle1("mrst_drain");

    // RD_LAT=3: back-to-back req0 len=1 then req1 len=1.
    begin
      int e_ov[10]   = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 0};
      int e_last[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
      int e_busy[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      int e_id[10]   = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
      int e_word[10] = '{0, 0, 0, 0, 4, 5, 0, 12, 13, 0};
      @(negedge clk);
      q0v = 1; q0b = 4; q0l = 1;
      #2;
      chk1("lat3_grant0", q0r, 1'b1);
      for (int off = 1; off < 10; off++) begin
        @(negedge clk);
        if (off == 1) begin q0v = 0; q1v = 1; q1b = 12; q1l = 1; end
        if (off == 4) q1v = 0;
        #2;
        if (off == 3) chk1("lat3_grant1", q1r, 1'b1);
        chk1($sformatf("lat3_valid_t%0d", off), ov3, e_ov[off][0]);
        chk1($sformatf("lat3_last_t%0d", off), olast3, e_last[off][0]);
        chk1($sformatf("lat3_busy_t%0d", off), busy3, e_busy[off][0]);
        if (e_ov[off] != 0) begin
          chk1($sformatf("lat3_id_t%0d", off), oid3, e_id[off][0]);
          chkd($sformatf("lat3_data_t%0d", off), od3, data_of(e_word[off][AW-1:0]));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
